tone_sequencer: RTL and testbench
=================================

Name: tone_sequencer

Overview:
Plays a melody from a note ROM through the audio codec path. It steps a ROM address at a tempo-controlled beat rate and latches each entry as a square-wave half-period. It generates a ±AMPLITUDE square wave and feeds samples to the Audio_Controller output handshake. It sits between the note ROM and the Audio_Controller, replacing ad-hoc rate-divider and tone logic at the top level.

Parameters:
ADDR_W, 10, ROM address width
PERIOD_W, 20, ROM word width; word = half-period in CLOCK_50 cycles, 0 = rest
LAST_ADDR, 252, final note address (inclusive)
BEAT_CYCLES, 9200000, CLOCK_50 cycles per note at normal tempo
FAST_BEAT_CYCLES, 7800000, cycles per note after the tempo switch
TEMPO_SWITCH_ADDR, 197, note address after which the fast tempo applies
AMPLITUDE, 1000000000, square-wave magnitude (signed 32-bit)

Ports:
CLOCK_50  input  1  system clock
resetn  input  1  asynchronous active-low reset
start  input  1  single-cycle pulse; begins playback from address 0
stop  input  1  single-cycle pulse; aborts playback
loop_en  input  1  1 = wrap to address 0 after LAST_ADDR; 0 = finish
mute  input  1  forces samples to 0 without pausing the sequence
rom_addr  output  ADDR_W  note ROM address; ROM is synchronous, 1-cycle read latency
rom_q  input  PERIOD_W  note ROM data
audio_out_allowed  input  1  Audio_Controller output FIFO has space
write_audio_out  output  1  sample write strobe
sample_out  output  32  signed sample, driven to both channels
playing  output  1  high in FETCH, LOAD or PLAY
done  output  1  one-cycle pulse when a non-looping playback completes

Behaviour:
- Reset (async, resetn=0): state IDLE, rom_addr=0, limit=BEAT_CYCLES, both counters 0, snd=0, sample_out=0, write_audio_out=0, playing=0, done=0.
- States:
  - IDLE: start -> FETCH with rom_addr=0 and limit=BEAT_CYCLES.
  - FETCH: exactly 1 cycle, lets the ROM read settle -> LOAD.
  - LOAD: latch period=rom_q; clear the half-period and beat counters; snd=0 -> PLAY.
  - PLAY: beat counter increments each cycle. When it equals limit-1, advance:
    - If rom_addr==TEMPO_SWITCH_ADDR, limit<=FAST_BEAT_CYCLES.
    - If rom_addr<LAST_ADDR: rom_addr+1 -> FETCH.
    - If rom_addr==LAST_ADDR and loop_en=1: rom_addr<=0, limit<=BEAT_CYCLES -> FETCH.
    - If rom_addr==LAST_ADDR and loop_en=0: -> DONE.
  - DONE: 1 cycle; done=1 -> IDLE with rom_addr=0.
- Note timing: each note occupies exactly limit cycles in PLAY plus 2 cycles for FETCH and LOAD.
- Tone generation (PLAY only, period!=0): half-period counter counts 0..period-1; at period-1 it wraps to 0 and snd toggles. Tone frequency = 50 MHz / (2*period).
- Rest: period==0 holds snd=0 and sample 0.
- Sample value (registered, updated every cycle): mute=1, rest, or state not PLAY -> 0; else snd ? +AMPLITUDE : -AMPLITUDE (two's complement).
- Handshake: write_audio_out = audio_out_allowed & (state==PLAY), combinational. One sample is written per allowed cycle; there is no backpressure stall on the sequence, and tempo never depends on audio_out_allowed.
- stop: any state -> IDLE next cycle; rom_addr=0, sample_out=0, done not pulsed. start and stop in the same cycle: stop wins.
- start outside IDLE is ignored.
- loop_en is sampled only at the LAST_ADDR advance.
- mute takes effect on the next sample_out update.
- resetn deasserted mid-playback returns to the reset state immediately; there is no resume.
- Width rules:
  - Beat counter is 27 bits and the half-period counter is PERIOD_W bits.
  - Comparisons are equality only.
  - limit must be ≥2 and LAST_ADDR < 2^ADDR_W.

Test Plan:
- Reset and idle: resetn low then high, no start -> sample_out=0, write_audio_out=0, playing=0, rom_addr=0 for 100 cycles.
- Basic note: BEAT_CYCLES=40, ROM[0]=5, audio_out_allowed=1, pulse start -> playing rises next cycle; snd toggles every 5 cycles during PLAY; sample alternates ±1000000000; rom_addr becomes 1 after 42 cycles.
- Tempo switch and wrap: LAST_ADDR=3, TEMPO_SWITCH_ADDR=1, BEAT_CYCLES=40, FAST_BEAT_CYCLES=20, loop_en=1 -> PLAY lengths are 40,40,20,20, then address 0 plays for 40 again.
- Non-loop finish: loop_en=0, LAST_ADDR=2 -> single done pulse after the third note; then playing=0, rom_addr=0, sample_out=0.
- Rest, mute and handshake: ROM[1]=0 -> sample_out=0 for the whole note. Toggling audio_out_allowed 1/0 -> write_audio_out mirrors it and rom_addr timing is unchanged. mute=1 -> sample_out=0 next cycle.
- Stop and collisions: stop mid-note -> IDLE next cycle with no done pulse. start and stop in the same cycle -> stays IDLE. resetn low during PLAY -> all outputs reset asynchronously.

Source files
------------

// File: rtl/tone_sequencer.sv
// Melody player: walks a synchronous note ROM at a tempo-controlled beat rate
// and turns each note's half-period into a +/-AMPLITUDE square-wave sample stream.
module tone_sequencer #(
  parameter int ADDR_W            = 10,
  parameter int PERIOD_W          = 20,
  parameter int LAST_ADDR         = 252,
  parameter int BEAT_CYCLES       = 9200000,
  parameter int FAST_BEAT_CYCLES  = 7800000,
  parameter int TEMPO_SWITCH_ADDR = 197,
  parameter int AMPLITUDE         = 1000000000
) (
  input  logic                CLOCK_50,
  input  logic                resetn,
  input  logic                start,
  input  logic                stop,
  input  logic                loop_en,
  input  logic                mute,
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic [PERIOD_W-1:0] rom_q,
  input  logic                audio_out_allowed,
  output logic                write_audio_out,
  output logic [31:0]         sample_out,
  output logic                playing,
  output logic                done
);

  localparam int BEAT_W = 27;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] FETCH = 3'd1;
  localparam logic [2:0] LOAD  = 3'd2;
  localparam logic [2:0] PLAY  = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  localparam logic [BEAT_W-1:0] NORMAL_LIMIT = BEAT_W'(BEAT_CYCLES);
  localparam logic [BEAT_W-1:0] FAST_LIMIT   = BEAT_W'(FAST_BEAT_CYCLES);
  localparam logic [ADDR_W-1:0] LAST         = ADDR_W'(LAST_ADDR);
  localparam logic [ADDR_W-1:0] SWITCH       = ADDR_W'(TEMPO_SWITCH_ADDR);
  localparam logic [31:0]       POS_AMP      = 32'(AMPLITUDE);
  localparam logic [31:0]       NEG_AMP      = -POS_AMP;

  logic [2:0]          state;
  logic [BEAT_W-1:0]   limit;
  logic [BEAT_W-1:0]   beat;
  logic [PERIOD_W-1:0] period;
  logic [PERIOD_W-1:0] half;
  logic                snd;
  logic                beat_end;
  logic                rest;

  assign beat_end = (beat == limit - BEAT_W'(1));
  assign rest     = (period == '0);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      rom_addr <= '0;
      limit    <= NORMAL_LIMIT;
      beat     <= '0;
      half     <= '0;
      period   <= '0;
      snd      <= 1'b0;
    end else if (stop) begin
      state    <= IDLE;
      rom_addr <= '0;
      beat     <= '0;
      half     <= '0;
      snd      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= FETCH;
            rom_addr <= '0;
            limit    <= NORMAL_LIMIT;
          end
        end

        FETCH: state <= LOAD;

        LOAD: begin
          period <= rom_q;
          beat   <= '0;
          half   <= '0;
          snd    <= 1'b0;
          state  <= PLAY;
        end

        PLAY: begin
          if (!rest) begin
            if (half == period - PERIOD_W'(1)) begin
              half <= '0;
              snd  <= ~snd;
            end else begin
              half <= half + PERIOD_W'(1);
            end
          end

          if (beat_end) begin
            // The switch note itself still plays at the old tempo.
            if (rom_addr == SWITCH) limit <= FAST_LIMIT;
            if (rom_addr != LAST) begin
              rom_addr <= rom_addr + ADDR_W'(1);
              state    <= FETCH;
            end else if (loop_en) begin
              rom_addr <= '0;
              limit    <= NORMAL_LIMIT;
              state    <= FETCH;
            end else begin
              state <= DONE;
            end
          end else begin
            beat <= beat + BEAT_W'(1);
          end
        end

        DONE: begin
          state    <= IDLE;
          rom_addr <= '0;
        end

        default: state <= IDLE;
      endcase
    end
  end

  // Sample is registered from the current state/snd, so it trails snd by a cycle.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      sample_out <= '0;
    end else if (stop || mute || rest || state != PLAY) begin
      sample_out <= '0;
    end else begin
      sample_out <= snd ? POS_AMP : NEG_AMP;
    end
  end

  // The sequence never stalls: a full FIFO simply drops that cycle's sample.
  assign write_audio_out = audio_out_allowed && (state == PLAY);
  assign playing         = (state == FETCH) || (state == LOAD) || (state == PLAY);
  assign done            = (state == DONE);

endmodule

// File: tb/tb_tone_sequencer.sv
// Directed bench for tone_sequencer with short tempo parameters and a 4-entry
// synchronous note ROM (5, rest, 3, 4).
module tb_tone_sequencer;

  localparam int ADDR_W = 10;
  localparam int PERIOD_W = 20;
  localparam logic [31:0] AMP = 32'd1000000000;
  localparam logic [31:0] NAMP = 32'hC4653600; // -1000000000

  logic                clk = 1'b0;
  logic                resetn = 1'b0;
  logic                start = 1'b0;
  logic                stop = 1'b0;
  logic                loop_en = 1'b0;
  logic                mute = 1'b0;
  logic [ADDR_W-1:0]   rom_addr;
  logic [PERIOD_W-1:0] rom_q;
  logic                audio_out_allowed = 1'b0;
  logic                write_audio_out;
  logic [31:0]         sample_out;
  logic                playing;
  logic                done;

  int passed = 0;
  int failed = 0;
  int total = 0;
  int n;

  logic [PERIOD_W-1:0] rom [0:3];

  always #10 clk = ~clk;

  always @(posedge clk) rom_q <= (rom_addr < 4) ? rom[rom_addr[1:0]] : '0;

  tone_sequencer #(
    .ADDR_W(ADDR_W), .PERIOD_W(PERIOD_W), .LAST_ADDR(3), .BEAT_CYCLES(40),
    .FAST_BEAT_CYCLES(20), .TEMPO_SWITCH_ADDR(1), .AMPLITUDE(1000000000)
  ) dut (
    .CLOCK_50(clk), .resetn(resetn), .start(start), .stop(stop),
    .loop_en(loop_en), .mute(mute), .rom_addr(rom_addr), .rom_q(rom_q),
    .audio_out_allowed(audio_out_allowed), .write_audio_out(write_audio_out),
    .sample_out(sample_out), .playing(playing), .done(done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected sample in PLAY cycle k (k=0 is the first PLAY cycle) for half-period p:
  // snd is low for p cycles, high for p, ...; the sample register lags snd by one.
  function automatic logic [31:0] tone(input int k, input int p);
    if (k == 0) return 32'd0;
    return ((((k - 1) / p) % 2) != 0) ? AMP : NAMP;
  endfunction

  task automatic measure(input logic [ADDR_W-1:0] a, output int cycles);
    cycles = 0;
    while (rom_addr == a && cycles < 200) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  initial begin
    rom[0] = 20'd5; rom[1] = 20'd0; rom[2] = 20'd3; rom[3] = 20'd4;

    // Reset state, then 100 idle cycles without start.
    repeat (3) @(negedge clk);
    check("rst_sample", sample_out, 32'd0);
    check("rst_ctrl", {29'd0, write_audio_out, playing, done}, 32'd0);
    check("rst_addr", 32'(rom_addr), 32'd0);
    resetn = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check("idle", {write_audio_out, playing, done, 19'(rom_addr), sample_out[9:0]} | 32'(sample_out != 0), 32'd0);
    end

    // Note 0: period 5, 40-cycle beat.
    audio_out_allowed = 1'b1;
    loop_en = 1'b1;
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("fetch_playing", 32'(playing), 32'd1);
    check("fetch_addr", 32'(rom_addr), 32'd0);
    @(negedge clk);
    check("load_sample", sample_out, 32'd0);
    check("load_write", 32'(write_audio_out), 32'd0);
    for (int k = 0; k <= 40; k++) begin
      @(negedge clk);
      check("n0_sample", sample_out, tone(k, 5));
      check("n0_addr", 32'(rom_addr), (k < 40) ? 32'd0 : 32'd1);
      check("n0_write", 32'(write_audio_out), (k < 40) ? 32'd1 : 32'd0);
    end

    // Note 1: rest; toggle audio_out_allowed, addr timing must not move.
    @(negedge clk);
    check("n1_load_sample", sample_out, 32'd0);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      audio_out_allowed = k[0];
      #1;
      check("n1_write", 32'(write_audio_out), 32'(k[0]));
      check("n1_rest", sample_out, 32'd0);
      check("n1_addr", 32'(rom_addr), 32'd1);
    end
    audio_out_allowed = 1'b1;
    @(negedge clk);
    check("n2_fetch_addr", 32'(rom_addr), 32'd2);
    check("n2_fetch_write", 32'(write_audio_out), 32'd0);

    // Note 2: period 3, fast tempo (20); mute for PLAY cycles 11..15.
    @(negedge clk);
    for (int k = 0; k <= 20; k++) begin
      @(negedge clk);
      check("n2_sample", sample_out, (k >= 11 && k <= 15) ? 32'd0 : tone(k, 3));
      if (k == 10) mute = 1'b1;
      if (k == 15) mute = 1'b0;
    end
    check("n3_fetch_addr", 32'(rom_addr), 32'd3);

    // Note 3 at fast tempo, then wrap to address 0 at normal tempo.
    measure(3, n);
    check("n3_len", 32'(n), 32'd22);
    check("wrap_addr", 32'(rom_addr), 32'd0);
    check("wrap_playing", 32'(playing), 32'd1);
    measure(0, n);
    check("wrap_n0_len", 32'(n), 32'd42);

    // Non-looping finish: addr1 (42) + addr2 (22) + addr3 (22) cycles to DONE.
    loop_en = 1'b0;
    n = 0;
    while (!done && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("done_latency", 32'(n), 32'd86);
    check("done_playing", 32'(playing), 32'd0);
    @(negedge clk);
    check("post_done", 32'(done), 32'd0);
    check("post_done_addr", 32'(rom_addr), 32'd0);
    check("post_done_sample", sample_out, 32'd0);
    check("post_done_playing", 32'(playing), 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("done_single", 32'(done), 32'd0);
    end

    // Stop mid-note.
    loop_en = 1'b1;
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (11) @(negedge clk);
    check("pre_stop_sample", sample_out, AMP);
    stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    check("stop_playing", 32'(playing), 32'd0);
    check("stop_addr", 32'(rom_addr), 32'd0);
    check("stop_sample", sample_out, 32'd0);
    check("stop_write", 32'(write_audio_out), 32'd0);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check("stop_idle", {30'd0, playing, done}, 32'd0);
    end

    // start and stop together: stop wins.
    start = 1'b1; stop = 1'b1;
    @(negedge clk); start = 1'b0; stop = 1'b0;
    check("collide_playing", 32'(playing), 32'd0);
    @(negedge clk);
    check("collide_idle", 32'(playing), 32'd0);

    // Asynchronous reset during PLAY.
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (13) @(negedge clk);
    check("pre_rst_sample", sample_out, NAMP);
    check("pre_rst_playing", 32'(playing), 32'd1);
    #3 resetn = 1'b0;
    #1;
    check("arst_playing", 32'(playing), 32'd0);
    check("arst_write", 32'(write_audio_out), 32'd0);
    check("arst_sample", sample_out, 32'd0);
    check("arst_addr", 32'(rom_addr), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    @(negedge clk); resetn = 1'b1;
    repeat (5) @(negedge clk);
    check("arst_no_resume", 32'(playing), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
